// File: rtl/hero_write_gather.sv
// hero_write_gather: packs single hero writes into one NUM_LANES-wide gathered word.
// A fill buffer collects lanes. A separate output register holds the frame being
// handed to the consumer, so filling continues while the consumer drains.
// Optional feature macro: HERO_WRITE_GATHER_TIMEOUT_EN flushes partial frames after
// TIMEOUT_CYC idle cycles.
module hero_write_gather #(
  parameter int unsigned HERO_WIDTH  = 32,
  parameter int unsigned NUM_LANES   = 5,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       in_cyc,
  input  logic [HERO_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*HERO_WIDTH-1:0]  out_data,
  output logic [NUM_LANES-1:0]             out_mask,
  output logic [$clog2(NUM_LANES+1)-1:0]   out_count,
  output logic                             out_last,
  output logic                             err_reserved
);

  localparam int unsigned CW = $clog2(NUM_LANES + 1);

  localparam logic [1:0] CycValid = 2'd1;
  localparam logic [1:0] CycDone  = 2'd2;
  localparam logic [1:0] CycRsvd  = 2'd3;

  typedef enum logic [0:0] {StFill, StWait} state_e;

  state_e r_state, w_state_next;

  logic [NUM_LANES-1:0][HERO_WIDTH-1:0] r_buf;
  logic [CW-1:0]                        r_ptr;
  logic                                 r_hold_last;

  logic [NUM_LANES-1:0][HERO_WIDTH-1:0] r_out_data;
  logic [NUM_LANES-1:0]                 r_out_mask;
  logic [CW-1:0]                        r_out_count;
  logic                                 r_out_last;
  logic                                 r_out_valid;
  logic                                 r_err;

  logic                                 w_accept;
  logic                                 w_beat_done;
  logic                                 w_timeout;
  logic                                 w_complete;
  logic                                 w_slot_free;
  logic                                 w_load;
  logic                                 w_hold;
  logic [NUM_LANES-1:0][HERO_WIDTH-1:0] w_frame_data;
  logic [NUM_LANES-1:0]                 w_frame_mask;
  logic [CW-1:0]                        w_frame_count;
  logic                                 w_frame_last;

  assign w_accept    = (r_state == StFill) && ((in_cyc == CycValid) || (in_cyc == CycDone));
  assign w_beat_done = w_accept && ((r_ptr == CW'(NUM_LANES - 1)) || (in_cyc == CycDone));
  assign w_complete  = w_beat_done || w_timeout;
  assign w_slot_free = !r_out_valid || out_ready;

`ifdef HERO_WRITE_GATHER_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_idle;

  assign w_idle    = (r_state == StFill) && (r_ptr != '0) && !w_accept;
  assign w_timeout = w_idle && (r_idle_cnt == 16'(TIMEOUT_CYC - 1));

  // Idle counter: counts empty cycles while a partial frame sits in the fill buffer.
  always_ff @(posedge clk) begin
    if (rst || w_complete || w_accept) begin
      r_idle_cnt <= '0;
    end else if (w_idle) begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  // Frame as it would be emitted now: buffered lanes plus the beat being accepted.
  // In WAIT nothing is accepted, so this is simply the held buffer.
  always_comb begin
    w_frame_data  = '0;
    w_frame_mask  = '0;
    w_frame_count = r_ptr + CW'(w_accept);
    w_frame_last  = (r_state == StWait) ? r_hold_last : (w_accept && (in_cyc == CycDone));
    for (int i = 0; i < NUM_LANES; i++) begin
      if (CW'(i) < r_ptr) begin
        w_frame_data[i] = r_buf[i];
      end else if ((CW'(i) == r_ptr) && w_accept) begin
        w_frame_data[i] = in_data;
      end
      w_frame_mask[i] = (CW'(i) < w_frame_count);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and transfer decisions.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_hold       = 1'b0;
    unique case (r_state)
      StFill: begin
        if (w_complete) begin
          if (w_slot_free) begin
            w_load = 1'b1;
          end else begin
            w_hold       = 1'b1;
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        if (out_ready) begin
          w_load       = 1'b1;
          w_state_next = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  // Fill buffer and lane pointer; stale lanes above the pointer are masked off on emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_ptr       <= '0;
      r_hold_last <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_accept && (CW'(i) == r_ptr)) begin
          r_buf[i] <= in_data;
        end
      end
      if (w_load) begin
        r_ptr <= '0;
      end else if (w_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_hold) begin
        r_hold_last <= w_frame_last;
      end
    end
  end

  // Output register: reloads on the same edge it is drained, so frames run back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (in_cyc == CycRsvd) && (r_state == StFill);
      if (w_load) begin
        r_out_data  <= w_frame_data;
        r_out_mask  <= w_frame_mask;
        r_out_count <= w_frame_count;
        r_out_last  <= w_frame_last;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready     = (r_state == StFill);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_mask     = r_out_mask;
  assign out_count    = r_out_count;
  assign out_last     = r_out_last;
  assign err_reserved = r_err;

endmodule

// File: tb/tb_hero_write_gather.sv
// Directed bench for hero_write_gather (5 lanes x 32 bits) with a frame scoreboard.
module tb_hero_write_gather;

  localparam int unsigned HW    = 32;
  localparam int unsigned LANES = 5;
  localparam int unsigned DW    = HW * LANES;
  localparam int unsigned CW    = $clog2(LANES + 1);

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [LANES-1:0] mask;
    logic [CW-1:0]    count;
    logic             last;
  } frame_t;

  logic             clk;
  logic             rst;
  logic [1:0]       in_cyc;
  logic [HW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_mask;
  logic [CW-1:0]    out_count;
  logic             out_last;
  logic             err_reserved;

  int checks   = 0;
  int failures = 0;

  frame_t        sb[$];
  logic [HW-1:0] m_lanes[LANES];
  int            m_ptr = 0;

  hero_write_gather #(
    .HERO_WIDTH (HW),
    .NUM_LANES  (LANES),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_cyc      (in_cyc),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mask    (out_mask),
    .out_count   (out_count),
    .out_last    (out_last),
    .err_reserved(err_reserved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Close the model frame and queue it as the next expected output.
  task automatic push(input logic last);
    frame_t f;
    f = '0;
    for (int i = 0; i < m_ptr; i++) begin
      f.data[i*HW +: HW] = m_lanes[i];
      f.mask[i]          = 1'b1;
    end
    f.count = CW'(m_ptr);
    f.last  = last;
    sb.push_back(f);
    m_ptr = 0;
  endtask

  // Compare any handshake about to happen, then advance one clock and settle.
  task automatic tick();
    frame_t f;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        failures++;
        $error("FAIL sb_unexpected_output observed=%0h expected=none", out_data);
      end
      if (sb.size() != 0) begin
        f = sb.pop_front();
        chk("sb_data", out_data, f.data);
        chk("sb_mask", DW'(out_mask), DW'(f.mask));
        chk("sb_count", DW'(out_count), DW'(f.count));
        chk("sb_last", DW'(out_last), DW'(f.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] cyc, input logic [HW-1:0] d);
    in_cyc  = cyc;
    in_data = d;
    chk("in_ready_at_beat", DW'(in_ready), DW'(1'b1));
    m_lanes[m_ptr] = d;
    m_ptr++;
    if (m_ptr == LANES || cyc == 2'd2) push(cyc == 2'd2);
    tick();
    in_cyc  = 2'd0;
    in_data = '0;
  endtask

  initial begin
    logic seen;
    logic [DW-1:0] held;
    rst       = 1'b1;
    in_cyc    = 2'd0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", DW'(out_mask), '0);
    chk("rst_out_count", DW'(out_count), '0);
    chk("rst_out_last", DW'(out_last), '0);
    chk("rst_err", DW'(err_reserved), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
    rst = 1'b0;
    tick();

    // Full frame of five VALID beats.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) beat(2'd1, HW'(i));
    chk("full_valid", DW'(out_valid), DW'(1'b1));
    chk("full_mask", DW'(out_mask), DW'(5'b11111));
    chk("full_count", DW'(out_count), DW'(5));
    chk("full_last", DW'(out_last), '0);
    chk("full_data", out_data, {32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
    tick();
    chk("full_drained", DW'(out_valid), '0);

    // DONE-terminated partial frame.
    beat(2'd1, 32'hA);
    beat(2'd1, 32'hB);
    beat(2'd2, 32'hC);
    chk("done_mask", DW'(out_mask), DW'(5'b00111));
    chk("done_count", DW'(out_count), DW'(3));
    chk("done_last", DW'(out_last), DW'(1'b1));
    chk("done_upper_zero", out_data >> 96, '0);
    chk("done_lanes", out_data, {64'h0, 32'hC, 32'hB, 32'hA});
    tick();

    // Continuous stream: in_ready checked on every beat, frames back-to-back.
    for (int i = 0; i < 10; i++) beat(2'd1, 32'h2000 + HW'(i));
    tick();
    chk("stream_drained", DW'(out_valid), '0);

    // Backpressure: first frame held, second frame parks in the fill buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(2'd1, 32'h100 + HW'(i));
    held = sb[0].data;
    for (int i = 5; i < 10; i++) beat(2'd1, 32'h100 + HW'(i));
    chk("bp_in_ready_low", DW'(in_ready), '0);
    chk("bp_held_valid", DW'(out_valid), DW'(1'b1));
    chk("bp_held_data", out_data, held);
    tick();
    tick();
    chk("bp_still_blocked", DW'(in_ready), '0);
    chk("bp_still_stable", out_data, held);
    out_ready = 1'b1;
    tick();
    chk("bp_second_valid", DW'(out_valid), DW'(1'b1));
    chk("bp_ready_back", DW'(in_ready), DW'(1'b1));
    tick();
    chk("bp_drained", DW'(out_valid), '0);
    chk("bp_sb_empty", DW'(sb.size()), '0);

    // Reserved cycle type: error pulse, no lane consumed.
    beat(2'd1, 32'h55);
    in_cyc  = 2'd3;
    in_data = 32'hDEAD;
    tick();
    chk("rsvd_pulse", DW'(err_reserved), DW'(1'b1));
    in_cyc = 2'd0;
    tick();
    chk("rsvd_pulse_end", DW'(err_reserved), '0);
    beat(2'd2, 32'h66);
    chk("rsvd_count", DW'(out_count), DW'(2));
    chk("rsvd_data", out_data, {96'h0, 32'h66, 32'h55});
    tick();

    // Reset with a held output and a partial frame.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(2'd1, 32'h300 + HW'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_ptr = 0;
    chk("midrst_valid", DW'(out_valid), '0);
    chk("midrst_in_ready", DW'(in_ready), DW'(1'b1));
    out_ready = 1'b1;
    beat(2'd2, 32'h77);
    chk("midrst_count", DW'(out_count), DW'(1));
    chk("midrst_mask", DW'(out_mask), DW'(5'b00001));
    chk("midrst_last", DW'(out_last), DW'(1'b1));
    tick();

    // Idle partial frame.
    beat(2'd1, 32'h81);
    beat(2'd1, 32'h82);
`ifdef HERO_WRITE_GATHER_TIMEOUT_EN
    push(1'b0);
    tick();
    tick();
    tick();
    chk("timeout_not_yet", DW'(out_valid), '0);
    tick();
    chk("timeout_valid", DW'(out_valid), DW'(1'b1));
    chk("timeout_count", DW'(out_count), DW'(2));
    chk("timeout_last", DW'(out_last), '0);
    tick();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("no_timeout_flush", DW'(seen), '0);
    beat(2'd2, 32'h83);
    chk("late_done_count", DW'(out_count), DW'(3));
    tick();
`endif
    chk("final_sb_empty", DW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
